// File: rtl/led_trail_pwm.sv
// Comet-trail LED driver: one-hot position -> per-LED fading PWM.
// Ports: clk, rst (async high), enable, pos[7:0] in; led[7:0], pos_err out.
module led_trail_pwm #(
  parameter int PWM_W      = 4,
  parameter int DECAY_DIV  = 16,
  parameter int DECAY_STEP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] pos,
  output logic [7:0] led,
  output logic       pos_err
);

  localparam int DW = $clog2(DECAY_DIV);
  localparam logic [PWM_W-1:0] MAX = '1;
  localparam logic [PWM_W:0] STEP = (PWM_W+1)'(DECAY_STEP);
  localparam logic [DW-1:0] DLAST = DW'(DECAY_DIV - 1);

  logic [PWM_W-1:0] r_pwm_cnt;
  logic [DW-1:0]    r_div_cnt;
  logic [PWM_W-1:0] r_bright [8];
  logic [7:0]       r_led;
  logic             r_pos_err;

  logic             w_tick;
  logic             w_onehot;
  logic [PWM_W:0]   w_ext [8];
  logic [PWM_W-1:0] w_dec [8];
  logic [7:0]       w_led;

  always_comb begin
    w_tick   = (r_div_cnt == DLAST);
    // x & (x-1) clears the lowest set bit; zero leftover means one bit
    w_onehot = (pos != 8'd0) &&
               ((pos & (pos - 8'd1)) == 8'd0);
    w_led    = '0;
    for (int i = 0; i < 8; i++) begin
      // one extra bit so the saturating subtract cannot wrap
      w_ext[i] = {1'b0, r_bright[i]};
      w_dec[i] = (w_ext[i] > STEP) ?
                 PWM_W'(w_ext[i] - STEP) : '0;
      w_led[i] = (r_bright[i] > r_pwm_cnt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm_cnt <= '0;
      r_div_cnt <= '0;
      r_led     <= '0;
      r_pos_err <= 1'b0;
      for (int i = 0; i < 8; i++)
        r_bright[i] <= '0;
    end else if (enable) begin
      r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
      r_div_cnt <= w_tick ? '0 : r_div_cnt + DW'(1);
      r_led     <= w_led;
      r_pos_err <= ~w_onehot;
      // refresh beats decay; malformed words still refresh every set bit
      for (int i = 0; i < 8; i++) begin
        if (pos[i])
          r_bright[i] <= MAX;
        else if (w_tick)
          r_bright[i] <= w_dec[i];
      end
    end else begin
      // counters hold, trail is wiped
      r_led     <= '0;
      r_pos_err <= 1'b0;
      for (int i = 0; i < 8; i++)
        r_bright[i] <= '0;
    end
  end

  assign led     = r_led;
  assign pos_err = r_pos_err;

endmodule

// File: tb/tb_led_trail_pwm.sv
// Bench for led_trail_pwm: random stimulus vs arithmetic trail model.
// Per-scenario tasks with inline checks, one summary line.
module tb_led_trail_pwm;

  localparam int P_MAX = 15;
  localparam int DIV   = 16;
  localparam int STEP  = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] pos = 8'h00;
  logic [7:0] led;
  logic       pos_err;

  int vectors = 0;
  int miss = 0;

  int         mb [8];
  int         mpwm;
  int         mdiv;
  logic [7:0] mled;
  logic       merr;

  led_trail_pwm #(
    .PWM_W(4), .DECAY_DIV(16), .DECAY_STEP(1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .pos(pos), .led(led), .pos_err(pos_err)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < 8; i++) mb[i] = 0;
    mpwm = 0;
    mdiv = 0;
    mled = 8'h00;
    merr = 1'b0;
  endtask

  task automatic step(input logic en, input logic [7:0] p);
    int tk;
    @(negedge clk);
    enable = en;
    pos = p;
    @(posedge clk);
    if (en) begin
      for (int i = 0; i < 8; i++) mled[i] = (mb[i] > mpwm);
      tk = (mdiv == DIV - 1) ? 1 : 0;
      for (int i = 0; i < 8; i++) begin
        if (p[i]) mb[i] = P_MAX;
        else if (tk != 0) mb[i] = (mb[i] > STEP) ? mb[i] - STEP : 0;
      end
      mpwm = (mpwm + 1) % (P_MAX + 1);
      mdiv = (mdiv + 1) % DIV;
      merr = ($countones(p) != 1);
    end else begin
      for (int i = 0; i < 8; i++) mb[i] = 0;
      mled = 8'h00;
      merr = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    pos = 8'h00;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [7:0] rand_hot();
    logic [7:0] v;
    v = 8'h01 << $urandom_range(0, 7);
    return v;
  endfunction

  task automatic test_reset();
    do_reset();
    vectors++;
    if (led !== 8'h00 || pos_err !== 1'b0) begin
      miss++;
      $display("FAIL reset_out: led=%h err=%b want 00/0", led, pos_err);
    end
    vectors++;
    if (dut.r_pwm_cnt !== 4'd0 || dut.r_div_cnt !== 4'd0) begin
      miss++;
      $display("FAIL reset_cnt: pwm=%0d div=%0d want 0/0",
               dut.r_pwm_cnt, dut.r_div_cnt);
    end
  endtask

  task automatic test_full_bright();
    int highs;
    highs = 0;
    do_reset();
    for (int n = 1; n <= 65; n++) begin
      step(1'b1, 8'h01);
      vectors++;
      if (led !== mled || pos_err !== merr) begin
        miss++;
        $display("FAIL full_out c%0d: led=%h err=%b want %h/%b",
                 n, led, pos_err, mled, merr);
      end
      if (n >= 2 && led[0]) highs++;
    end
    vectors++;
    if (highs !== 60) begin
      miss++;
      $display("FAIL full_duty: high=%0d want 60", highs);
    end
  endtask

  task automatic test_decay();
    int ticks;
    int prev;
    int zero_hi;
    ticks = 0;
    zero_hi = 0;
    do_reset();
    for (int n = 0; n < 20; n++) step(1'b1, 8'h01);
    prev = int'(dut.r_bright[0]);
    step(1'b1, 8'h02);
    vectors++;
    if (dut.r_bright[1] !== 4'd15) begin
      miss++;
      $display("FAIL decay_refresh: b1=%0d want 15", dut.r_bright[1]);
    end
    for (int n = 0; n < 280; n++) begin
      if (int'(dut.r_bright[0]) < prev) ticks++;
      prev = int'(dut.r_bright[0]);
      vectors++;
      if (led !== mled || pos_err !== merr) begin
        miss++;
        $display("FAIL decay_out c%0d: led=%h err=%b want %h/%b",
                 n, led, pos_err, mled, merr);
      end
      if (n >= 260 && led[0]) zero_hi++;
      step(1'b1, 8'h02);
    end
    vectors++;
    if (ticks !== 15) begin
      miss++;
      $display("FAIL decay_ticks: got=%0d want 15", ticks);
    end
    vectors++;
    if (zero_hi !== 0) begin
      miss++;
      $display("FAIL decay_dark: led0 high=%0d want 0", zero_hi);
    end
  endtask

  task automatic test_refresh_priority();
    int n;
    do_reset();
    step(1'b1, 8'h04);
    n = 0;
    while (n < 400 && !(mb[2] == 7 && mdiv == DIV - 1)) begin
      step(1'b1, 8'h08);
      vectors++;
      if (led !== mled || pos_err !== merr) begin
        miss++;
        $display("FAIL prio_out: led=%h err=%b want %h/%b",
                 led, pos_err, mled, merr);
      end
      n++;
    end
    vectors++;
    if (n >= 400) begin
      miss++;
      $display("FAIL prio_timeout: cycles=%0d want <400", n);
    end
    vectors++;
    if (dut.r_bright[2] !== 4'd7) begin
      miss++;
      $display("FAIL prio_pre: b2=%0d want 7", dut.r_bright[2]);
    end
    step(1'b1, 8'h04);
    vectors++;
    if (dut.r_bright[2] !== 4'd15) begin
      miss++;
      $display("FAIL prio_refresh: b2=%0d want 15", dut.r_bright[2]);
    end
  endtask

  task automatic test_malformed();
    do_reset();
    for (int n = 0; n < 5; n++) step(1'b1, rand_hot());
    step(1'b1, 8'h00);
    vectors++;
    if (pos_err !== 1'b1) begin
      miss++;
      $display("FAIL err_zero: err=%b want 1", pos_err);
    end
    step(1'b1, 8'h81);
    vectors++;
    if (pos_err !== 1'b1) begin
      miss++;
      $display("FAIL err_multi: err=%b want 1", pos_err);
    end
    vectors++;
    if (dut.r_bright[0] !== 4'd15 || dut.r_bright[7] !== 4'd15) begin
      miss++;
      $display("FAIL multi_bright: b0=%0d b7=%0d want 15/15",
               dut.r_bright[0], dut.r_bright[7]);
    end
    step(1'b1, 8'h10);
    vectors++;
    if (pos_err !== 1'b0 || led !== mled) begin
      miss++;
      $display("FAIL err_clear: led=%h err=%b want %h/0",
               led, pos_err, mled);
    end
  endtask

  task automatic test_enable_drop();
    int pw;
    int dv;
    do_reset();
    for (int k = 0; k < 8; k++)
      for (int n = 0; n < 48; n++) step(1'b1, 8'h01 << k);
    pw = mpwm;
    dv = mdiv;
    step(1'b0, 8'h40);
    vectors++;
    if (led !== 8'h00 || pos_err !== 1'b0) begin
      miss++;
      $display("FAIL dis_out: led=%h err=%b want 00/0", led, pos_err);
    end
    vectors++;
    if (int'(dut.r_pwm_cnt) !== pw || int'(dut.r_div_cnt) !== dv) begin
      miss++;
      $display("FAIL dis_freeze: pwm=%0d div=%0d want %0d/%0d",
               dut.r_pwm_cnt, dut.r_div_cnt, pw, dv);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (dut.r_bright[i] !== 4'd0) begin
        miss++;
        $display("FAIL dis_bright%0d: got=%0d want 0", i, dut.r_bright[i]);
      end
    end
    for (int n = 0; n < 20; n++) begin
      step(1'b1, 8'h10);
      vectors++;
      if (led !== mled || (led & 8'hEF) !== 8'h00) begin
        miss++;
        $display("FAIL reen_out c%0d: led=%h want %h", n, led, mled);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int n = 0; n < 37; n++) step(1'b1, rand_hot());
    #1;
    rst = 1'b1;
    #1;
    model_clear();
    vectors++;
    if (led !== 8'h00 || pos_err !== 1'b0 ||
        dut.r_pwm_cnt !== 4'd0 || dut.r_div_cnt !== 4'd0) begin
      miss++;
      $display("FAIL arst: led=%h err=%b pwm=%0d div=%0d want zeros",
               led, pos_err, dut.r_pwm_cnt, dut.r_div_cnt);
    end
    #1;
    rst = 1'b0;
    for (int n = 0; n < 40; n++) begin
      step(1'b1, (n < 20) ? 8'h02 : 8'h20);
      vectors++;
      if (led !== mled || pos_err !== merr) begin
        miss++;
        $display("FAIL arst_run c%0d: led=%h err=%b want %h/%b",
                 n, led, pos_err, mled, merr);
      end
    end
  endtask

  task automatic test_random();
    logic       en;
    logic [7:0] p;
    logic [7:0] cur;
    do_reset();
    cur = rand_hot();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) == 0) cur = rand_hot();
      en = ($urandom_range(0, 19) != 0);
      p = ($urandom_range(0, 11) == 0) ? 8'($urandom) : cur;
      step(en, p);
      vectors++;
      if (led !== mled || pos_err !== merr) begin
        miss++;
        $display("FAIL rand c%0d: led=%h err=%b want %h/%b",
                 n, led, pos_err, mled, merr);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_full_bright();
    test_decay();
    test_refresh_priority();
    test_malformed();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule
